// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Constants and helpers shared by the FIR filter and its output
//             FIFO stage.
//  Contents : SAMPLE_W  - filter output sample width (default FIFO WIDTH)
//             CNT_W()   - width of an occupancy counter able to hold 0..depth
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int SAMPLE_W = 8;

  // Occupancy must represent DEPTH itself (full), hence one bit more than
  // the pointer width.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fir_fifo_mem
//  Purpose  : DEPTH x WIDTH register array, one synchronous write port and
//             one asynchronous read port. All words clear on reset.
//  Ports    : clk    - clock (rising edge)
//             reset  - asynchronous active-low reset
//             we     - write enable
//             waddr  - write address
//             wdata  - write data
//             raddr  - read address
//             rdata  - read data (combinational from raddr)
//  Revision : 1.0 - initial release
// ============================================================================
module fir_fifo_mem
  import fir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fir_fifo_mem
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_out_fifo
//  Purpose  : Output buffer behind the FIR filter. Optionally decimates the
//             enabled sample stream, buffers samples in a first-word-fall-
//             through FIFO and drops (and flags) samples arriving when full.
//  Ports    : clk        - clock (rising edge)
//             reset      - asynchronous active-low reset
//             in_en      - din carries a valid filter sample
//             din        - filter sample
//             dout       - head-of-FIFO sample, 0 when empty
//             dout_valid - FIFO non-empty
//             dout_ready - sink takes dout this cycle
//             count      - occupancy 0..DEPTH
//             overflow   - sticky drop flag
//             clr_ovf    - synchronous clear of overflow
//  Revision : 1.0 - initial release
// ============================================================================
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 16,
  parameter int DECIM = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [CNT_W(DEPTH)-1:0] count,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = CNT_W(DEPTH);
  // Five bits cover every legal decimation phase (0..15).
  localparam int DW = 5;

  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [DW-1:0]    dcnt_q,   dcnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic             accept;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    accept = in_en && (dcnt_q == '0);
    full   = (count_q == FULL_CNT);
    empty  = (count_q == '0);
    pop    = !empty && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push   = accept && (!full || pop);
    drop   = accept && full && !pop;

    dcnt_d = dcnt_q;
    if (in_en) begin
      dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // A drop in the same cycle as a clear request wins.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dcnt_q   <= dcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  fir_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Stale words remain in storage after a pop, so the head is masked when
  // the FIFO is empty.
  assign dout       = empty ? '0 : rd_data;
  assign dout_valid = !empty;
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule : fir_out_fifo
`default_nettype wire

// File: tb/tb_fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_out_fifo
//  Purpose  : Self-checking bench for fir_out_fifo (DECIM=1 and DECIM=4
//             instances, DEPTH=16, WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_fifo;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_en, rdy, clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic [4:0] count;
  logic       overflow;

  logic       d_en, d_rdy, d_clr;
  logic [7:0] d_din;
  logic [7:0] d_dout;
  logic       d_valid;
  logic [4:0] d_count;
  logic       d_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_out_fifo #(.WIDTH(8), .DEPTH(16), .DECIM(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_en      (in_en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (rdy),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr)
  );

  fir_out_fifo #(.WIDTH(8), .DEPTH(16), .DECIM(4)) u_dec (
    .clk        (clk),
    .reset      (reset),
    .in_en      (d_en),
    .din        (d_din),
    .dout       (d_dout),
    .dout_valid (d_valid),
    .dout_ready (d_rdy),
    .count      (d_count),
    .overflow   (d_ovf),
    .clr_ovf    (d_clr)
  );

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_valid;
    logic [4:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [7:0] d, input logic r, input logic c,
                     input logic [7:0] ed, input logic ev, input logic [4:0] ec,
                     input logic eo);
    vec_t v;
    v.en = en; v.din = d; v.rdy = r; v.clr = c;
    v.e_dout = ed; v.e_valid = ev; v.e_cnt = ec; v.e_ovf = eo;
    tv.push_back(v);
  endtask

  task automatic chk_main(input string tag, input logic [7:0] ed, input logic ev,
                          input logic [4:0] ec, input logic eo);
    chk({tag, ".dout"},     32'(dout),       32'(ed));
    chk({tag, ".valid"},    32'(dout_valid), 32'(ev));
    chk({tag, ".count"},    32'(count),      32'(ec));
    chk({tag, ".overflow"}, 32'(overflow),   32'(eo));
  endtask

  task automatic chk_dec(input string tag, input logic [7:0] ed, input logic ev,
                         input logic [4:0] ec);
    chk({tag, ".dout"},  32'(d_dout),  32'(ed));
    chk({tag, ".valid"}, 32'(d_valid), 32'(ev));
    chk({tag, ".count"}, 32'(d_count), 32'(ec));
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Pass-through: each sample on dout one edge after input, count stays 1.
    for (int i = 1; i <= 20; i++) add(1'b1, 8'(i), 1'b1, 1'b0, 8'(i), 1'b1, 5'd1, 1'b0);
    // Drain last sample, then a pop request while empty.
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    // Fill with 0x10..0x23; 0x20 onwards dropped.
    for (int k = 0; k < 20; k++)
      add(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 8'h10, 1'b1,
          (k < 16) ? 5'(k + 1) : 5'd16, (k >= 16));
    // Clear overflow while idle.
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 5'd16, 1'b0);
    // Full: push 0x55 with simultaneous pop of 0x10.
    add(1'b1, 8'h55, 1'b1, 1'b0, 8'h11, 1'b1, 5'd16, 1'b0);
    // Drop together with clr_ovf: set wins.
    add(1'b1, 8'h77, 1'b0, 1'b1, 8'h11, 1'b1, 5'd16, 1'b1);
    // Drain: 0x11..0x1F then 0x55.
    for (int j = 0; j < 16; j++)
      add(1'b0, 8'h00, 1'b1, 1'b0,
          (j < 14) ? 8'(8'h12 + j) : ((j == 14) ? 8'h55 : 8'h00),
          (j < 15), 5'(15 - j), 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 1'b0);
    // Load 7 entries (overflow then raised again by a deliberate drop? no:
    // keep it clear) ahead of the mid-stream reset.
    for (int k = 0; k < 7; k++)
      add(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 8'h30, 1'b1, 5'(k + 1), 1'b0);

    // ---------------- reset / idle ----------------
    reset = 1'b0;
    in_en = 1'b1; din = 8'hA5; rdy = 1'b0; clr = 1'b0;
    d_en  = 1'b1; d_din = 8'hA5; d_rdy = 1'b0; d_clr = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk_main("reset", 8'h00, 1'b0, 5'd0, 1'b0);
      chk("reset.dec_count", 32'(d_count), 32'd0);
      tick();
    end
    reset = 1'b1;
    d_en  = 1'b0;

    // ---------------- table run ----------------
    foreach (tv[n]) begin
      in_en = tv[n].en; din = tv[n].din; rdy = tv[n].rdy; clr = tv[n].clr;
      tick();
      chk_main($sformatf("vec%0d", n), tv[n].e_dout, tv[n].e_valid, tv[n].e_cnt, tv[n].e_ovf);
    end

    // ---------------- mid-stream reset ----------------
    in_en = 1'b0; rdy = 1'b0; clr = 1'b0;
    reset = 1'b0;
    #2;
    chk_main("midrst", 8'h00, 1'b0, 5'd0, 1'b0);
    reset = 1'b1;
    in_en = 1'b1; din = 8'h99;
    tick();
    chk_main("post_rst", 8'h99, 1'b1, 5'd1, 1'b0);
    in_en = 1'b0; rdy = 1'b1;
    tick();
    chk_main("post_rst_pop", 8'h00, 1'b0, 5'd0, 1'b0);
    rdy = 1'b0;

    // ---------------- decimation by 4 ----------------
    d_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d_din = 8'(i);
      tick();
      if (i == 0) chk_dec("dec_first", 8'h00, 1'b1, 5'd1);
    end
    d_en = 1'b0;
    chk_dec("dec_fill", 8'h00, 1'b1, 5'd4);
    d_rdy = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk_dec($sformatf("dec_drain%0d", j), (j < 4) ? 8'(4 * j) : 8'h00, (j < 4), 5'(4 - j));
    end
    d_rdy = 1'b0;
    // Pause in_en mid-stream: phase must hold, so 16 and 20 are kept.
    d_en = 1'b1; d_din = 8'd16; tick();
    d_din = 8'd17; tick();
    d_en = 1'b0; d_din = 8'hEE;
    repeat (3) tick();
    d_en = 1'b1;
    for (int i = 18; i <= 22; i++) begin
      d_din = 8'(i);
      tick();
    end
    d_en = 1'b0;
    chk_dec("dec_pause", 8'd16, 1'b1, 5'd2);
    d_rdy = 1'b1;
    tick();
    chk_dec("dec_pause_pop1", 8'd20, 1'b1, 5'd1);
    tick();
    chk_dec("dec_pause_pop2", 8'h00, 1'b0, 5'd0);
    chk("dec_ovf", 32'(d_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fir_out_fifo
`default_nettype wire
